// File: rtl/sync_fifo_flags_if.sv
// Producer/consumer bundle for sync_fifo_flags: write/read requests, data and status.
interface sync_fifo_flags_if #(
    parameter int WIDTH     = 8,
    parameter int PTR_WIDTH = 4
) ();
    logic [WIDTH-1:0]   wdata_i;
    logic               wr_en_i;
    logic               rd_en_i;
    logic [WIDTH-1:0]   rdata_o;
    logic               full_o;
    logic               empty_o;
    logic               almost_full_o;
    logic               almost_empty_o;
    logic [PTR_WIDTH:0] count_o;
    logic               wr_error_o;
    logic               rd_error_o;

    // Side that issues pushes/pops and observes status.
    modport master (
        output wdata_i, wr_en_i, rd_en_i,
        input  rdata_o, full_o, empty_o, almost_full_o, almost_empty_o,
               count_o, wr_error_o, rd_error_o
    );

    // The FIFO itself.
    modport slave (
        input  wdata_i, wr_en_i, rd_en_i,
        output rdata_o, full_o, empty_o, almost_full_o, almost_empty_o,
               count_o, wr_error_o, rd_error_o
    );
endinterface

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty thresholds,
// registered error pulses and a selectable first-word-fall-through read port.
module sync_fifo_flags #(
    parameter int DEPTH     = 16,
    parameter int WIDTH     = 8,
    parameter int PTR_WIDTH = 4,
    parameter int AF_LEVEL  = 12,
    parameter int AE_LEVEL  = 4,
    parameter int FWFT      = 0
) (
    input logic               clk_i,
    input logic               rst_i,
    sync_fifo_flags_if.slave  bus
);
    localparam int CNT_W = PTR_WIDTH + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_LEVEL);

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [PTR_WIDTH-1:0] wr_ptr;
    logic [PTR_WIDTH-1:0] rd_ptr;
    logic [CNT_W-1:0]     count_q;
    logic [CNT_W-1:0]     count_nxt;
    logic                 full_q;
    logic                 empty_q;
    logic                 af_q;
    logic                 ae_q;
    logic                 wr_err_q;
    logic                 rd_err_q;
    logic                 wr_acc;
    logic                 rd_acc;

    // Occupancy after one edge; the accept rules keep it inside 0..DEPTH.
    function automatic logic [CNT_W-1:0] next_count(input logic [CNT_W-1:0] cnt,
                                                    input logic wa, input logic ra);
        return cnt + CNT_W'(wa) - CNT_W'(ra);
    endfunction

    // Accept decisions from registered flags; a pop frees a slot for a write when full.
    always_comb begin
        wr_acc    = bus.wr_en_i & (~full_q | bus.rd_en_i);
        rd_acc    = bus.rd_en_i & ~empty_q;
        count_nxt = next_count(count_q, wr_acc, rd_acc);
    end

    // Pointers, count, flags and error pulses; flags track the next count so they move with count_o.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            af_q     <= 1'b0;
            ae_q     <= 1'b1;
            wr_err_q <= 1'b0;
            rd_err_q <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
            count_q  <= count_nxt;
            full_q   <= (count_nxt == DEPTH_C);
            empty_q  <= (count_nxt == '0);
            af_q     <= (count_nxt >= AF_C);
            ae_q     <= (count_nxt <= AE_C);
            wr_err_q <= bus.wr_en_i & ~wr_acc;
            rd_err_q <= bus.rd_en_i & ~rd_acc;
        end
    end

    // Storage write; contents survive reset but requests during reset are ignored.
    always_ff @(posedge clk_i) begin
        if (!rst_i && wr_acc) mem[wr_ptr] <= bus.wdata_i;
    end

    generate
        if (FWFT == 0) begin : g_std
            logic [WIDTH-1:0] rdata_q;
            // Registered read: data appears the cycle after an accepted pop and holds otherwise.
            always_ff @(posedge clk_i) begin
                if (rst_i)       rdata_q <= '0;
                else if (rd_acc) rdata_q <= mem[rd_ptr];
            end
            assign bus.rdata_o = rdata_q;
        end else begin : g_fwft
            // Head of queue shown directly; forced to zero while empty so reset reads 0.
            assign bus.rdata_o = empty_q ? '0 : mem[rd_ptr];
        end
    endgenerate

    assign bus.count_o        = count_q;
    assign bus.full_o         = full_q;
    assign bus.empty_o        = empty_q;
    assign bus.almost_full_o  = af_q;
    assign bus.almost_empty_o = ae_q;
    assign bus.wr_error_o     = wr_err_q;
    assign bus.rd_error_o     = rd_err_q;
endmodule

// File: tb/tb_sync_fifo_flags.sv
// Bench for sync_fifo_flags: standard and FWFT instances share one stimulus stream,
// a queue model is compared every cycle, and directed steps pin literal values.
module tb_sync_fifo_flags;
    localparam int DEPTH = 16;
    localparam int AF    = 12;
    localparam int AE    = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] wdata = '0;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sync_fifo_flags_if #(.WIDTH(8), .PTR_WIDTH(4)) if0 ();
    sync_fifo_flags_if #(.WIDTH(8), .PTR_WIDTH(4)) if1 ();

    assign if0.wdata_i = wdata;
    assign if0.wr_en_i = wr_en;
    assign if0.rd_en_i = rd_en;
    assign if1.wdata_i = wdata;
    assign if1.wr_en_i = wr_en;
    assign if1.rd_en_i = rd_en;

    sync_fifo_flags #(.DEPTH(DEPTH), .WIDTH(8), .PTR_WIDTH(4), .AF_LEVEL(AF),
                      .AE_LEVEL(AE), .FWFT(0)) dut_std (.clk_i(clk), .rst_i(rst), .bus(if0));
    sync_fifo_flags #(.DEPTH(DEPTH), .WIDTH(8), .PTR_WIDTH(4), .AF_LEVEL(AF),
                      .AE_LEVEL(AE), .FWFT(1)) dut_fwft (.clk_i(clk), .rst_i(rst), .bus(if1));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a queue plus the last popped word and the error bits.
    logic [7:0] mq[$];
    logic [7:0] m_rdata = '0;
    logic       m_wr_err = 1'b0;
    logic       m_rd_err = 1'b0;
    bit         started = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_rdata  = '0;
            m_wr_err = 1'b0;
            m_rd_err = 1'b0;
            started  = 1'b1;
        end else if (started) begin
            bit is_full, is_empty, wa, ra;
            is_full  = (mq.size() == DEPTH);
            is_empty = (mq.size() == 0);
            wa = wr_en && (!is_full || rd_en);
            ra = rd_en && !is_empty;
            if (ra) m_rdata = mq.pop_front();
            if (wa) mq.push_back(wdata);
            m_wr_err = wr_en && !wa;
            m_rd_err = rd_en && !ra;
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (started) begin
            int n;
            n = mq.size();
            chk("count",     32'(if0.count_o),       32'(n));
            chk("empty",     32'(if0.empty_o),       32'(n == 0));
            chk("full",      32'(if0.full_o),        32'(n == DEPTH));
            chk("afull",     32'(if0.almost_full_o), 32'(n >= AF));
            chk("aempty",    32'(if0.almost_empty_o),32'(n <= AE));
            chk("wr_err",    32'(if0.wr_error_o),    32'(m_wr_err));
            chk("rd_err",    32'(if0.rd_error_o),    32'(m_rd_err));
            chk("rdata",     32'(if0.rdata_o),       32'(m_rdata));
            chk("f_count",   32'(if1.count_o),       32'(n));
            chk("f_empty",   32'(if1.empty_o),       32'(n == 0));
            chk("f_wr_err",  32'(if1.wr_error_o),    32'(m_wr_err));
            chk("f_rd_err",  32'(if1.rd_error_o),    32'(m_rd_err));
            if (n > 0) chk("f_rdata", 32'(if1.rdata_o), 32'(mq[0]));
        end
    end

    task automatic cyc(input logic w, input logic r, input logic [7:0] d);
        wr_en = w;
        rd_en = r;
        wdata = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset
        rst = 1'b1;
        cyc(1'b1, 1'b1, 8'hEE);
        rst = 1'b0;
        chk("rst_count",  32'(if0.count_o), 0);
        chk("rst_empty",  32'(if0.empty_o), 1);
        chk("rst_aempty", 32'(if0.almost_empty_o), 1);
        chk("rst_full",   32'(if0.full_o), 0);
        chk("rst_afull",  32'(if0.almost_full_o), 0);
        chk("rst_errs",   32'({if0.wr_error_o, if0.rd_error_o}), 0);
        chk("rst_rdata",  32'(if0.rdata_o), 0);

        // Fill 0x01..0x10
        for (int i = 1; i <= 16; i++) begin
            cyc(1'b1, 1'b0, 8'(i));
            chk("fill_count", 32'(if0.count_o), 32'(i));
            if (i == 11) chk("afull_11", 32'(if0.almost_full_o), 0);
            if (i == 12) chk("afull_12", 32'(if0.almost_full_o), 1);
            if (i == 15) chk("full_15", 32'(if0.full_o), 0);
        end
        chk("full_16", 32'(if0.full_o), 1);
        cyc(1'b1, 1'b0, 8'h99);
        chk("ovf_err",   32'(if0.wr_error_o), 1);
        chk("ovf_count", 32'(if0.count_o), 16);
        cyc(1'b0, 1'b0, 8'h00);
        chk("ovf_pulse_end", 32'(if0.wr_error_o), 0);

        // Drain in order
        for (int i = 1; i <= 16; i++) begin
            chk("fwft_head", 32'(if1.rdata_o), 32'(i));
            cyc(1'b0, 1'b1, 8'h00);
            chk("drain_data",  32'(if0.rdata_o), 32'(i));
            chk("drain_count", 32'(if0.count_o), 32'(16 - i));
            if (i == 11) chk("aempty_5", 32'(if0.almost_empty_o), 0);
            if (i == 12) chk("aempty_4", 32'(if0.almost_empty_o), 1);
        end
        chk("drain_empty", 32'(if0.empty_o), 1);
        cyc(1'b0, 1'b1, 8'h00);
        chk("unf_err",  32'(if0.rd_error_o), 1);
        chk("unf_hold", 32'(if0.rdata_o), 8'h10);
        cyc(1'b0, 1'b0, 8'h00);
        chk("unf_pulse_end", 32'(if0.rd_error_o), 0);

        // Simultaneous read/write while full
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 8'(8'h20 + i));
        cyc(1'b1, 1'b1, 8'hAA);
        chk("full_rw_err",   32'(if0.wr_error_o), 0);
        chk("full_rw_count", 32'(if0.count_o), 16);
        chk("full_rw_data",  32'(if0.rdata_o), 8'h20);
        for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, 8'h00);
        chk("aa_out", 32'(if0.rdata_o), 8'hAA);
        chk("aa_empty", 32'(if0.empty_o), 1);

        // Simultaneous read/write while empty
        cyc(1'b1, 1'b1, 8'h55);
        chk("empty_rw_rderr", 32'(if0.rd_error_o), 1);
        chk("empty_rw_count", 32'(if0.count_o), 1);
        chk("empty_rw_fwft",  32'(if1.rdata_o), 8'h55);
        cyc(1'b0, 1'b1, 8'h00);
        chk("empty_rw_read", 32'(if0.rdata_o), 8'h55);

        // FWFT fall-through
        cyc(1'b1, 1'b0, 8'h3C);
        chk("fwft_nempty", 32'(if1.empty_o), 0);
        chk("fwft_data",   32'(if1.rdata_o), 8'h3C);
        cyc(1'b0, 1'b1, 8'h00);
        chk("fwft_popped", 32'(if1.empty_o), 1);

        // Reset mid-stream
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 8'(8'h60 + i));
        rst = 1'b1;
        cyc(1'b1, 1'b0, 8'h77);
        rst = 1'b0;
        chk("mrst_count",  32'(if0.count_o), 0);
        chk("mrst_empty",  32'(if0.empty_o), 1);
        chk("mrst_aempty", 32'(if0.almost_empty_o), 1);
        chk("mrst_errs",   32'({if0.wr_error_o, if0.rd_error_o}), 0);

        // Random push/pop against the model; write-biased then read-biased to wrap pointers
        for (int k = 0; k < 40; k++) begin
            logic w, r;
            w = ($urandom_range(0, 9) < ((k < 20) ? 8 : 3));
            r = ($urandom_range(0, 9) < ((k < 20) ? 2 : 7));
            cyc(w, r, 8'($urandom));
        end
        cyc(1'b0, 1'b0, 8'h00);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
